serial_tx_ctrl: RTL and testbench
=================================

# serial_tx_ctrl

Frame sequencer for a 9-bit right-shifting serial register: accepts a byte over a valid/ready handshake, loads it with a start bit into an internal 9-bit shift register, and paces shifts with a bit-period counter. It emits an asynchronous-serial frame on `tx`: start 0, 8 data bits LSB first, stop 1. It sits between the byte-producing logic and the serial output pin.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per serial bit. Legal values are ≥ 2.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `data`  in  8  byte to transmit; sampled only on the accept edge.
- `send`  in  1  request/valid; may be held high.
- `ready`  out  1  high only in IDLE; a transfer is accepted on an edge where `send && ready`.
- `tx`  out  1  serial line. Equals `sr[0]` of the internal shift register; idles high.
- `done`  out  1  one-cycle pulse on the edge that returns to IDLE after the stop bit.
- `busy`  out  1  equal to `!ready`.

## Operation
- Internal state:
  - `sr[8:0]`: the shift register.
  - `state`: one of IDLE, DATA, STOP.
  - `bit_cnt[3:0]`: bit counter.
  - `baud_cnt`: width `$clog2(CLKS_PER_BIT)`.
- Reset (async, while `rst_n`=0):
  - `sr`=9'h1FF, so `tx`=1.
  - `state`=IDLE, `ready`=1, `busy`=0, `done`=0.
  - `bit_cnt`=0, `baud_cnt`=0.
- Shift-register control:
  - Load: `sr <= {data, 1'b0}`.
  - Shift: `sr <= (sr >> 1) | (1 << 8)`, inserting 1 at the MSB.
  - Hold: no change.
  - Load and shift are never both active.
- IDLE:
  - `sr` holds 9'h1FF.
  - On `send` = 1: load `sr`, clear `baud_cnt` and `bit_cnt`, go to DATA.
- DATA:
  - `baud_cnt` increments each cycle.
  - At `baud_cnt == CLKS_PER_BIT-1`: clear `baud_cnt`, shift `sr`, increment `bit_cnt`.
  - If `bit_cnt` was 8 (the 9th shift), go to STOP. After that shift `sr[0]`=1, which is the stop bit.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles.
  - At terminal count: go to IDLE and assert `done` for exactly one cycle.
- Input handling:
  - `send` while busy is ignored. There is no queueing, and the request is not remembered.
  - `data` changes after the accept edge do not affect the frame in flight.

## Timing
- Accept edge is E0 (`send`=1, `ready`=1):
  - From E0+1 cycle: `tx`=0 (start bit), `ready`=0.
  - Bit k (k=0 start, k=1..8 data[k-1], k=9 stop) occupies cycles `[E0 + k·N + 1, E0 + (k+1)·N]`, where N=`CLKS_PER_BIT`.
- Frame length:
  - `ready` returns to 1, and `done` pulses, in the cycle after the last stop-bit cycle: `10·N` cycles after E0.
  - `tx` changes only on bit boundaries and is glitch-free, since it is a register bit.
- Back-to-back:
  - With `send` held high, the next accept occurs on the first IDLE cycle.
  - Frame period is `10·N + 1` cycles; the stop/idle high lasts N+1 cycles.
- Reset mid-frame:
  - `tx` goes to 1 immediately and asynchronously; the frame is abandoned.
  - No `done` pulse.
  - `ready`=1 from reset assertion onward.
  - First accept is possible on the first edge after release.
- `done` and `ready` are both high in the return-to-IDLE cycle. If `send`=1 in that cycle, a new frame is accepted in that cycle.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle with no clock edge → `tx`=1, `ready`=1, `busy`=0, `done`=0 immediately.
- **Single frame:** N=4, `data`=8'hA5, `send` pulsed for one cycle.
  - `tx` bits, each held 4 cycles: 0,1,0,1,0,0,1,0,1 then stop 1.
  - `ready`=0 for 40 cycles.
  - `done` pulses exactly once, 40 cycles after accept.
- **Back-to-back:** `send` held high, `data`=8'h00 then 8'hFF.
  - Second start bit begins 41 cycles after the first.
  - Frame 1: `tx` low for 36 consecutive cycles.
  - Frame 2: `tx` low for only its 4-cycle start bit.
- **Ignored request / data stability:** while busy, pulse `send` and change `data` to 8'h3C → current frame bits unchanged, no second frame after `done`.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 → `tx`=1 asynchronously, no `done`. After release, send 8'h81 → clean full frame 0,1,0,0,0,0,0,0,1,1.
- **Parameter sweep:** `CLKS_PER_BIT`=2 and 7 with 8'h5A → bit widths 2 and 7 cycles, `ready` low 20 and 70 cycles respectively.

Source files
------------

// File: rtl/serial_tx_ctrl_if.sv
// serial_tx_ctrl_if
// Byte handshake and serial-line bundle for serial_tx_ctrl.
//   data   : byte to transmit, producer -> transmitter
//   send   : request/valid, producer -> transmitter
//   ready  : transmitter idle, a byte is accepted on send && ready
//   busy   : inverse of ready
//   done   : one-cycle pulse when a frame completes
//   tx     : serial line output
// The master modport is the byte producer; the slave modport is the transmitter.
interface serial_tx_ctrl_if;
    logic [7:0] data;
    logic       send;
    logic       ready;
    logic       busy;
    logic       done;
    logic       tx;

    modport master (
        output data,
        output send,
        input  ready,
        input  busy,
        input  done,
        input  tx
    );

    modport slave (
        input  data,
        input  send,
        output ready,
        output busy,
        output done,
        output tx
    );
endinterface

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl
// Asynchronous-serial frame sequencer. A byte accepted over the valid/ready
// handshake is loaded with a start bit into a 9-bit right-shifting register
// and shifted out LSB first, one bit every CLKS_PER_BIT cycles, followed by a
// stop bit held for one bit period.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : serial_tx_ctrl_if slave modport (data, send, ready, busy, done, tx)
// Parameter:
//   CLKS_PER_BIT : clock cycles per serial bit, must be >= 2
module serial_tx_ctrl #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_tx_ctrl_if.slave bus
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [8:0]          sr_q, sr_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [BAUD_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;

    // Next-state logic. DATA covers the start bit and the eight data bits:
    // nine shifts in total, the last of which brings the inserted 1 into
    // sr[0] so the stop bit needs no extra load. STOP only times the stop
    // bit; the register already reads 9'h1FF and just holds.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        baud_cnt_d = baud_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    sr_d       = {bus.data, 1'b0};
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = DATA;
                end
            end

            DATA: begin
                if (baud_cnt_q == BAUD_MAX) begin
                    baud_cnt_d = '0;
                    sr_d       = {1'b1, sr_q[8:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd8) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            STOP: begin
                if (baud_cnt_q == BAUD_MAX) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + BAUD_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // ready is registered from the next state so it lines up exactly
        // with the cycles the FSM spends in IDLE.
        ready_d = (state_d == IDLE);
    end

    // State register. Reset forces sr to all ones so the line idles high
    // immediately, even when reset lands in the middle of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= 9'h1FF;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            baud_cnt_q <= baud_cnt_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx    = sr_q[0];
    assign bus.ready = ready_q;
    assign bus.busy  = !ready_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb_serial_tx_ctrl
// Directed testbench for serial_tx_ctrl. Three instances (N = 4, 2, 7) share
// clock and reset; sel chooses which one receives send and is observed.
module tb_serial_tx_ctrl;

    logic       clk;
    logic       rst_n;
    logic       send_r;
    logic [7:0] data_r;
    int         sel;
    int         tests_run;
    int         tests_failed;

    serial_tx_ctrl_if b4 ();
    serial_tx_ctrl_if b2 ();
    serial_tx_ctrl_if b7 ();

    serial_tx_ctrl #(.CLKS_PER_BIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));
    serial_tx_ctrl #(.CLKS_PER_BIT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    serial_tx_ctrl #(.CLKS_PER_BIT(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(b7.slave));

    assign b4.data = data_r;
    assign b2.data = data_r;
    assign b7.data = data_r;
    assign b4.send = (sel == 0) && send_r;
    assign b2.send = (sel == 1) && send_r;
    assign b7.send = (sel == 2) && send_r;

    logic m_tx, m_ready, m_busy, m_done;
    assign m_tx    = (sel == 1) ? b2.tx    : (sel == 2) ? b7.tx    : b4.tx;
    assign m_ready = (sel == 1) ? b2.ready : (sel == 2) ? b7.ready : b4.ready;
    assign m_busy  = (sel == 1) ? b2.busy  : (sel == 2) ? b7.busy  : b4.busy;
    assign m_done  = (sel == 1) ? b2.done  : (sel == 2) ? b7.done  : b4.done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one frame on the selected instance, starting at a negedge with the
    // DUT idle. Samples s_0..s_10N, where s_j is the negedge after accept
    // edge E0 + j cycles. Bit k is expected over s_kN..s_(k+1)N-1, ready and
    // done high at s_10N. poke_j injects a data change (and, unless send is
    // held, a one-cycle send pulse) mid-frame.
    task automatic run_frame(input int n, input logic [7:0] d, input bit hold,
                             input bit already, input int poke_j,
                             input logic [7:0] poke_d, input string name,
                             output int tx_low, output int rdy_low);
        logic exp_tx;
        logic exp_rdy;
        int   k;
        tx_low  = 0;
        rdy_low = 0;
        if (!already) begin
            data_r = d;
            send_r = 1'b1;
        end
        for (int j = 0; j <= 10 * n; j++) begin
            @(negedge clk);
            if (j == 0 && !hold) send_r = 1'b0;
            if (j == poke_j) begin
                data_r = poke_d;
                if (!hold) send_r = 1'b1;
            end
            if (j == poke_j + 1 && !hold) send_r = 1'b0;
            k = j / n;
            if (k == 0)      exp_tx = 1'b0;
            else if (k <= 8) exp_tx = d[k-1];
            else             exp_tx = 1'b1;
            exp_rdy = (j == 10 * n);
            if (m_tx === 1'b0)    tx_low++;
            if (m_ready === 1'b0) rdy_low++;
            tests_run++;
            if (m_tx !== exp_tx) begin
                tests_failed++;
                $display("[TB] FAIL %s tx s%0d: got %b expected %b", name, j, m_tx, exp_tx);
            end
            tests_run++;
            if (m_ready !== exp_rdy) begin
                tests_failed++;
                $display("[TB] FAIL %s ready s%0d: got %b expected %b", name, j, m_ready, exp_rdy);
            end
            tests_run++;
            if (m_busy !== !exp_rdy) begin
                tests_failed++;
                $display("[TB] FAIL %s busy s%0d: got %b expected %b", name, j, m_busy, !exp_rdy);
            end
            tests_run++;
            if (m_done !== exp_rdy) begin
                tests_failed++;
                $display("[TB] FAIL %s done s%0d: got %b expected %b", name, j, m_done, exp_rdy);
            end
        end
    endtask

    // Checks the selected instance stays idle with no done pulse.
    task automatic check_idle(input int cycles, input string name);
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            tests_run++;
            if (m_tx !== 1'b1 || m_ready !== 1'b1 || m_done !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL %s idle c%0d: got tx=%b ready=%b done=%b expected tx=1 ready=1 done=0",
                         name, j, m_tx, m_ready, m_done);
            end
        end
    endtask

    task automatic check_count(input int got, input int exp, input string name);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests_run++;
        if (b4.tx !== 1'b1 || b4.ready !== 1'b1 || b4.busy !== 1'b0 || b4.done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s: got tx=%b ready=%b busy=%b done=%b expected 1 1 0 0",
                     name, b4.tx, b4.ready, b4.busy, b4.done);
        end
    endtask

    task automatic test_reset();
        #7;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_async");
        tests_run++;
        if (b2.tx !== 1'b1 || b7.tx !== 1'b1 || b2.ready !== 1'b1 || b7.ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_sweep_insts: got tx2=%b tx7=%b rdy2=%b rdy7=%b expected all 1",
                     b2.tx, b7.tx, b2.ready, b7.ready);
        end
        @(negedge clk);
        check_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        int tl, rl;
        sel = 0;
        run_frame(4, 8'hA5, 1'b0, 1'b0, -10, 8'h00, "single", tl, rl);
        check_count(rl, 40, "single_ready_low_cycles");
        check_count(tl, 20, "single_tx_low_cycles");
        check_idle(4, "single_after");
    endtask

    task automatic test_back_to_back();
        int tl, rl;
        sel = 0;
        run_frame(4, 8'h00, 1'b1, 1'b0, 0, 8'hFF, "b2b_f1", tl, rl);
        check_count(tl, 36, "b2b_f1_tx_low_cycles");
        run_frame(4, 8'hFF, 1'b0, 1'b1, -10, 8'h00, "b2b_f2", tl, rl);
        check_count(tl, 4, "b2b_f2_tx_low_cycles");
        check_count(rl, 40, "b2b_f2_ready_low_cycles");
        check_idle(3, "b2b_after");
    endtask

    task automatic test_ignored_request();
        int tl, rl;
        sel = 0;
        run_frame(4, 8'hA5, 1'b0, 1'b0, 8, 8'h3C, "ignored", tl, rl);
        check_count(rl, 40, "ignored_ready_low_cycles");
        check_idle(12, "ignored_no_second_frame");
    endtask

    task automatic test_reset_mid_frame();
        int tl, rl;
        sel = 0;
        data_r = 8'hA5;
        send_r = 1'b1;
        for (int j = 0; j <= 21; j++) begin
            @(negedge clk);
            if (j == 0) send_r = 1'b0;
        end
        tests_run++;
        if (b4.tx !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_pre_tx: got %b expected 0", b4.tx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset_async");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_reset_outputs("midreset_held");
        end
        rst_n = 1'b1;
        run_frame(4, 8'h81, 1'b0, 1'b0, -10, 8'h00, "after_reset", tl, rl);
        check_count(tl, 28, "after_reset_tx_low_cycles");
        check_idle(3, "after_reset_idle");
    endtask

    task automatic test_param_sweep();
        int tl, rl;
        sel = 1;
        run_frame(2, 8'h5A, 1'b0, 1'b0, -10, 8'h00, "sweep_n2", tl, rl);
        check_count(rl, 20, "sweep_n2_ready_low_cycles");
        check_idle(3, "sweep_n2_after");
        sel = 2;
        run_frame(7, 8'h5A, 1'b0, 1'b0, -10, 8'h00, "sweep_n7", tl, rl);
        check_count(rl, 70, "sweep_n7_ready_low_cycles");
        check_idle(8, "sweep_n7_after");
        sel = 0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b1;
        send_r       = 1'b0;
        data_r       = 8'h00;
        sel          = 0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_request();
        test_reset_mid_frame();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
